dense_activate_pipe_fifo: RTL and testbench

//   Elastic dense->activate pipeline stage: carries the same payload bundle as the fixed delay stage,

---
 rtl/dense_activate_pipe_fifo.sv | 139 +++++++++++++
 tb/tb_dense_activate_pipe_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_activate_pipe_fifo.sv
// Elastic dense->activate stage: valid/ready FIFO of depth entries carrying the dense payload bundle.
// Optional feature macro: DENSE_ACT_STALL_CNT_EN adds the 32-bit stall_cnt output.
module dense_activate_pipe_fifo #(
    parameter int size            = 3,
    parameter int data_size       = 16,
    parameter int cost_type_size  = 8,
    parameter int dense_type_size = 4,
    parameter int act_type_size   = 4,
    parameter int depth           = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic [$clog2(depth+1)-1:0]    level,
    input  logic [act_type_size-1:0]      act_type,
    input  logic [dense_type_size-1:0]    dense_type,
    input  logic [cost_type_size-1:0]     cost_type,
    input  logic [data_size*size-1:0]     w,
    input  logic [data_size*size-1:0]     y,
    input  logic [data_size*size-1:0]     x,
    input  logic [data_size*size-1:0]     label,
    input  logic [31:0]                   w_layer_index,
    input  logic [31:0]                   w_row_index,
    input  logic                          is_update,
    input  logic                          backprop_cost,
    output logic [act_type_size-1:0]      act_type_out,
    output logic [dense_type_size-1:0]    dense_type_out,
    output logic [cost_type_size-1:0]     cost_type_out,
    output logic [data_size*size-1:0]     w_out,
    output logic [data_size*size-1:0]     y_out,
    output logic [data_size*size-1:0]     x_out,
    output logic [data_size*size-1:0]     label_out,
    output logic [31:0]                   w_layer_index_out,
    output logic [31:0]                   w_row_index_out,
    output logic                          is_update_out,
`ifdef DENSE_ACT_STALL_CNT_EN
    output logic [31:0]                   stall_cnt,
`endif
    output logic                          backprop_cost_out
);

    localparam int VEC_W   = data_size * size;
    localparam int ENTRY_W = act_type_size + dense_type_size + cost_type_size + 4 * VEC_W + 64 + 2;
    localparam int PTR_W   = (depth > 1) ? $clog2(depth) : 1;
    localparam int LVL_W   = $clog2(depth + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(depth - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(depth);

    logic [ENTRY_W-1:0] mem_r [depth];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [ENTRY_W-1:0] entry_s;
    logic [ENTRY_W-1:0] head_s;
    logic               push_s;
    logic               pop_s;

    // Pointers wrap at depth-1 so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign in_ready  = (level_r < FULL_LVL);
    assign out_valid = (level_r != '0);
    assign level     = level_r;
    assign push_s    = in_valid & in_ready & ~flush;
    assign pop_s     = out_valid & out_ready & ~flush;

    assign entry_s = {act_type, dense_type, cost_type, w, y, x, label,
                      w_layer_index, w_row_index, is_update, backprop_cost};

    // Head entry is presented only while valid; otherwise outputs read as zero.
    always_comb begin
        head_s = '0;
        if (out_valid) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign {act_type_out, dense_type_out, cost_type_out, w_out, y_out, x_out, label_out,
            w_layer_index_out, w_row_index_out, is_update_out, backprop_cost_out} = head_s;

    // Storage, pointers and occupancy; reset also scrubs storage, flush only empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

`ifdef DENSE_ACT_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where the head is held by downstream back-pressure.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stall_cnt_r <= 32'd0;
        end else if (out_valid && !out_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_dense_activate_pipe_fifo.sv
// Directed self-checking bench for dense_activate_pipe_fifo (depth=2 and depth=3 instances).
module tb_dense_activate_pipe_fifo;

    localparam int VW = 48;
    localparam int BW = 4 + 4 + 8 + 4 * VW + 64 + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  act_type = '0, dense_type = '0;
    logic [7:0]  cost_type = '0;
    logic [VW-1:0] w = '0, y = '0, x = '0, label = '0;
    logic [31:0] w_layer_index = '0, w_row_index = '0;
    logic        is_update = 1'b0, backprop_cost = 1'b0;

    logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic v3 = 1'b0, r3 = 1'b0, f3 = 1'b0;

    logic ir2, ov2, ir3, ov3;
    logic [1:0] lv2, lv3;
    logic [3:0] oa2, od2, oa3, od3;
    logic [7:0] oc2, oc3;
    logic [VW-1:0] ow2, oy2, ox2, ol2, ow3, oy3, ox3, ol3;
    logic [31:0] oli2, ori2, oli3, ori3, sc2, sc3;
    logic ou2, ob2, ou3, ob3;
    logic [BW-1:0] o2, o3;

    assign o2 = {oa2, od2, oc2, ow2, oy2, ox2, ol2, oli2, ori2, ou2, ob2};
    assign o3 = {oa3, od3, oc3, ow3, oy3, ox3, ol3, oli3, ori3, ou3, ob3};

    int checks = 0;
    int failures = 0;

    dense_activate_pipe_fifo #(.depth(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .out_valid(ov2),
        .out_ready(out_ready), .flush(flush), .level(lv2),
        .act_type(act_type), .dense_type(dense_type), .cost_type(cost_type),
        .w(w), .y(y), .x(x), .label(label), .w_layer_index(w_layer_index),
        .w_row_index(w_row_index), .is_update(is_update), .backprop_cost(backprop_cost),
        .act_type_out(oa2), .dense_type_out(od2), .cost_type_out(oc2),
        .w_out(ow2), .y_out(oy2), .x_out(ox2), .label_out(ol2),
        .w_layer_index_out(oli2), .w_row_index_out(ori2), .is_update_out(ou2),
`ifdef DENSE_ACT_STALL_CNT_EN
        .stall_cnt(sc2),
`endif
        .backprop_cost_out(ob2)
    );

    dense_activate_pipe_fifo #(.depth(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ir3), .out_valid(ov3),
        .out_ready(r3), .flush(f3), .level(lv3),
        .act_type(act_type), .dense_type(dense_type), .cost_type(cost_type),
        .w(w), .y(y), .x(x), .label(label), .w_layer_index(w_layer_index),
        .w_row_index(w_row_index), .is_update(is_update), .backprop_cost(backprop_cost),
        .act_type_out(oa3), .dense_type_out(od3), .cost_type_out(oc3),
        .w_out(ow3), .y_out(oy3), .x_out(ox3), .label_out(ol3),
        .w_layer_index_out(oli3), .w_row_index_out(ori3), .is_update_out(ou3),
`ifdef DENSE_ACT_STALL_CNT_EN
        .stall_cnt(sc3),
`endif
        .backprop_cost_out(ob3)
    );

    // Distinct, recognisable payload for entry n.
    function automatic logic [BW-1:0] pl(input int n);
        logic [15:0] e;
        logic [VW-1:0] wv, yv, xv, lv;
        e  = 16'(n);
        wv = {e + 16'd2, e + 16'd1, e};
        yv = {e + 16'h1002, e + 16'h1001, e + 16'h1000};
        xv = {e + 16'h2002, e + 16'h2001, e + 16'h2000};
        lv = {e + 16'h3002, e + 16'h3001, e + 16'h3000};
        return {4'(n), 4'(n + 1), 8'(n * 3), wv, yv, xv, lv, 32'(n * 100), 32'(n + 7), n[0], n[1]};
    endfunction

    task automatic set_payload(input int n);
        {act_type, dense_type, cost_type, w, y, x, label,
         w_layer_index, w_row_index, is_update, backprop_cost} = pl(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov2); end
        checks++; if (lv2 !== 2'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", lv2); end
        checks++; if (ir2 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir2); end
        checks++; if (o2 !== '0) begin failures++; $display("FAIL reset_payload got=%h exp=0", o2); end
        checks++; if (ov3 !== 1'b0 || lv3 !== 2'd0 || ir3 !== 1'b1) begin
            failures++; $display("FAIL reset_d3 got ov=%b lv=%0d ir=%b exp 0/0/1", ov3, lv3, ir3);
        end
`ifdef DENSE_ACT_STALL_CNT_EN
        checks++; if (sc2 !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", sc2); end
`endif
        tick();
        checks++; if (ov2 !== 1'b0 || lv2 !== 2'd0) begin
            failures++; $display("FAIL reset_idle got ov=%b lv=%0d exp 0/0", ov2, lv2);
        end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_payload(1);
        tick();
        checks++; if (ov2 !== 1'b1 || lv2 !== 2'd1) begin
            failures++; $display("FAIL hold_first got ov=%b lv=%0d exp 1/1", ov2, lv2);
        end
        checks++; if (o2 !== pl(1)) begin failures++; $display("FAIL hold_first_data got=%h exp=%h", o2, pl(1)); end
        set_payload(2);
        tick();
        checks++; if (lv2 !== 2'd2 || ir2 !== 1'b0) begin
            failures++; $display("FAIL hold_full got lv=%0d ir=%b exp 2/0", lv2, ir2);
        end
        checks++; if (o2 !== pl(1)) begin failures++; $display("FAIL hold_stable got=%h exp=%h", o2, pl(1)); end
        set_payload(3);
        tick();
        in_valid = 1'b0;
        checks++; if (lv2 !== 2'd2 || o2 !== pl(1)) begin
            failures++; $display("FAIL hold_no_overfill got lv=%0d data=%h exp 2/%h", lv2, o2, pl(1));
        end
    endtask

    task automatic test_flush();
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_payload(9);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (lv2 !== 2'd0 || ov2 !== 1'b0 || ir2 !== 1'b1) begin
            failures++; $display("FAIL flush_empty got lv=%0d ov=%b ir=%b exp 0/0/1", lv2, ov2, ir2);
        end
        checks++; if (o2 !== '0) begin failures++; $display("FAIL flush_payload got=%h exp=0", o2); end
        tick();
        checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL flush_discard got ov=%b exp=0", ov2); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            set_payload(k);
            tick();
            checks++; if (ov2 !== 1'b1 || lv2 !== 2'd1 || o2 !== pl(k)) begin
                failures++;
                $display("FAIL b2b_entry%0d got ov=%b lv=%0d data=%h exp 1/1/%h", k, ov2, lv2, o2, pl(k));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (ov2 !== 1'b0 || lv2 !== 2'd0) begin
            failures++; $display("FAIL b2b_drain got ov=%b lv=%0d exp 0/0", ov2, lv2);
        end
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_payload(5);
        tick();
        set_payload(6);
        tick();
        in_valid = 1'b0;
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        checks++; if (lv2 !== 2'd0 || ov2 !== 1'b0 || ir2 !== 1'b1 || o2 !== '0) begin
            failures++; $display("FAIL rst_mid got lv=%0d ov=%b ir=%b data=%h exp 0/0/1/0", lv2, ov2, ir2, o2);
        end
    endtask

    task automatic test_random_depth3();
        int q[$];
        int sent = 11;
        int got = 0;
        int cyc = 0;
        bit do_push, do_pop;
        while (got < 10 && cyc < 300) begin
            v3 = (sent <= 20);
            if (v3) set_payload(sent);
            r3 = 1'($urandom_range(0, 1));
            #1;
            checks++; if (ov3 !== (q.size() != 0) || ir3 !== (q.size() < 3) || lv3 !== 2'(q.size())) begin
                failures++;
                $display("FAIL rnd_status cyc=%0d got ov=%b ir=%b lv=%0d exp size=%0d", cyc, ov3, ir3, lv3, q.size());
            end
            do_push = v3 && (q.size() < 3);
            do_pop  = r3 && (q.size() != 0);
            if (do_pop) begin
                checks++; if (o3 !== pl(q[0])) begin
                    failures++; $display("FAIL rnd_data got=%h exp=%h", o3, pl(q[0]));
                end
                void'(q.pop_front());
                got++;
            end
            if (do_push) begin
                q.push_back(sent);
                sent++;
            end
            tick();
            cyc++;
        end
        v3 = 1'b0;
        r3 = 1'b0;
        checks++; if (got != 10) begin failures++; $display("FAIL rnd_count got=%0d exp=10", got); end
        checks++; if (lv3 !== 2'd0 || ov3 !== 1'b0) begin
            failures++; $display("FAIL rnd_final got lv=%0d ov=%b exp 0/0", lv3, ov3);
        end
    endtask

`ifdef DENSE_ACT_STALL_CNT_EN
    task automatic test_stall_cnt();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (sc2 !== 32'd0) begin failures++; $display("FAIL stall_clear0 got=%0d exp=0", sc2); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_payload(4);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (sc2 !== 32'd5) begin failures++; $display("FAIL stall_count got=%0d exp=5", sc2); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (sc2 !== 32'd0 || lv2 !== 2'd0) begin
            failures++; $display("FAIL stall_flush got cnt=%0d lv=%0d exp 0/0", sc2, lv2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hold();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        test_random_depth3();
`ifdef DENSE_ACT_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
